// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU multiplier slice.
package fpu_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  localparam float32_t FLOAT32_QNAN = 32'hFFC00000;

endpackage

// File: rtl/fpu_mult_initiator.sv
// Initiator for the FPU multiplier stb/ack protocol: sends operand A then B,
// collects the product, returns it with its tag and measured latency, and
// aborts any single wait that exceeds TIMEOUT cycles.
module fpu_mult_initiator #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_a_stb,
  output logic             mul_b_stb,
  input  logic             mul_a_ack,
  input  logic             mul_b_ack,
  input  logic [31:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             mul_z_ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_z,
  output logic [TAG_W-1:0] res_tag,
  output logic [15:0]      res_cycles,
  output logic             busy,
  output logic             timeout_err
);
  import fpu_pkg::*;

  // Watchdog must be able to hold TIMEOUT itself without wrapping.
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           r_state, w_nstate;
  float32_t         r_mul_a, r_mul_b, r_res_z;
  logic [TAG_W-1:0] r_op_tag, r_res_tag;
  logic [15:0]      r_cnt, r_res_cycles;
  logic [WD_W-1:0]  r_wd;
  logic r_op_ready, r_mul_a_stb, r_mul_b_stb, r_mul_z_ack;
  logic r_res_valid, r_busy, r_timeout_err;
  logic w_accept, w_a_xfer, w_b_xfer, w_z_xfer, w_res_xfer, w_any_xfer;
  logic w_waiting, w_expire;
  logic w_op_ready_d, w_a_stb_d, w_b_stb_d, w_z_ack_d, w_res_valid_d, w_busy_d;

  // op_ready is only high in IDLE, so gating on it also blocks the first
  // cycle after reset release.
  assign w_accept   = r_op_ready && op_valid;
  assign w_a_xfer   = (r_state == ST_SEND_A) && r_mul_a_stb && mul_a_ack;
  assign w_b_xfer   = (r_state == ST_SEND_B) && r_mul_b_stb && mul_b_ack;
  assign w_z_xfer   = (r_state == ST_WAIT_Z) && r_mul_z_ack && mul_z_stb;
  assign w_res_xfer = (r_state == ST_OUTPUT) && r_res_valid && res_ready;
  assign w_any_xfer = w_a_xfer || w_b_xfer || w_z_xfer;
  assign w_waiting  = (r_state == ST_SEND_A) || (r_state == ST_SEND_B) ||
                      (r_state == ST_WAIT_Z);
  // A transfer on the expiry edge takes priority over the abort.
  assign w_expire   = w_waiting && !w_any_xfer && (r_wd == WD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_nstate = ST_SEND_A;
      ST_SEND_A: if (w_a_xfer) w_nstate = ST_SEND_B;
                 else if (w_expire) w_nstate = ST_IDLE;
      ST_SEND_B: if (w_b_xfer) w_nstate = ST_WAIT_Z;
                 else if (w_expire) w_nstate = ST_IDLE;
      ST_WAIT_Z: if (w_z_xfer) w_nstate = ST_OUTPUT;
                 else if (w_expire) w_nstate = ST_IDLE;
      ST_OUTPUT: if (w_res_xfer) w_nstate = ST_IDLE;
      default:   w_nstate = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    w_op_ready_d  = (w_nstate == ST_IDLE);
    w_a_stb_d     = (w_nstate == ST_SEND_A);
    w_b_stb_d     = (w_nstate == ST_SEND_B);
    w_z_ack_d     = (w_nstate == ST_WAIT_Z);
    w_res_valid_d = (w_nstate == ST_OUTPUT);
    w_busy_d      = (w_nstate != ST_IDLE);
  end

  // Registered handshake/status outputs; timeout_err is sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_ready    <= 1'b0;
      r_mul_a_stb   <= 1'b0;
      r_mul_b_stb   <= 1'b0;
      r_mul_z_ack   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_op_ready    <= w_op_ready_d;
      r_mul_a_stb   <= w_a_stb_d;
      r_mul_b_stb   <= w_b_stb_d;
      r_mul_z_ack   <= w_z_ack_d;
      r_res_valid   <= w_res_valid_d;
      r_busy        <= w_busy_d;
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

  // Operand/result capture, latency counter and per-wait watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_op_tag     <= '0;
      r_res_z      <= '0;
      r_res_tag    <= '0;
      r_res_cycles <= '0;
      r_cnt        <= '0;
      r_wd         <= '0;
    end else begin
      if (w_accept) begin
        r_mul_a  <= op_a;
        r_mul_b  <= op_b;
        r_op_tag <= op_tag;
        r_cnt    <= '0;
        r_wd     <= '0;
      end else if (w_waiting) begin
        r_cnt <= sat_inc16(r_cnt);
        r_wd  <= w_any_xfer ? '0 : r_wd + WD_W'(1);
      end
      if (w_z_xfer) begin
        r_res_z      <= mul_z;
        r_res_tag    <= r_op_tag;
        r_res_cycles <= sat_inc16(r_cnt);
      end
    end
  end

  assign op_ready    = r_op_ready;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign mul_a_stb   = r_mul_a_stb;
  assign mul_b_stb   = r_mul_b_stb;
  assign mul_z_ack   = r_mul_z_ack;
  assign res_valid   = r_res_valid;
  assign res_z       = r_res_z;
  assign res_tag     = r_res_tag;
  assign res_cycles  = r_res_cycles;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fpu_mult_initiator.sv
// Bench for fpu_mult_initiator: a short-watchdog instance covers protocol,
// backpressure, timeout and reset; a long-watchdog instance covers latency
// saturation. Expected results are queued when each op is issued.
`timescale 1ns/1ps
module tb_fpu_mult_initiator;
  import fpu_pkg::*;

  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
    logic [15:0]      cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst, rst_big, use_big;
  logic op_valid, mul_a_ack, mul_b_ack, mul_z_stb, res_ready;
  logic [31:0] op_a, op_b, mul_z;
  logic [TAG_W-1:0] op_tag;

  logic s_op_ready, s_mul_a_stb, s_mul_b_stb, s_mul_z_ack, s_res_valid, s_busy, s_timeout_err;
  logic [31:0] s_mul_a, s_mul_b, s_res_z;
  logic [TAG_W-1:0] s_res_tag;
  logic [15:0] s_res_cycles;
  logic b_op_ready, b_mul_a_stb, b_mul_b_stb, b_mul_z_ack, b_res_valid, b_busy, b_timeout_err;
  logic [31:0] b_mul_a, b_mul_b, b_res_z;
  logic [TAG_W-1:0] b_res_tag;
  logic [15:0] b_res_cycles;

  // Observed view: whichever instance the current test targets
  logic v_op_ready, v_mul_a_stb, v_mul_b_stb, v_mul_z_ack, v_res_valid, v_busy, v_timeout_err;
  logic [31:0] v_mul_a, v_mul_b, v_res_z;
  logic [TAG_W-1:0] v_res_tag;
  logic [15:0] v_res_cycles;
  assign v_op_ready    = use_big ? b_op_ready    : s_op_ready;
  assign v_mul_a_stb   = use_big ? b_mul_a_stb   : s_mul_a_stb;
  assign v_mul_b_stb   = use_big ? b_mul_b_stb   : s_mul_b_stb;
  assign v_mul_z_ack   = use_big ? b_mul_z_ack   : s_mul_z_ack;
  assign v_res_valid   = use_big ? b_res_valid   : s_res_valid;
  assign v_busy        = use_big ? b_busy        : s_busy;
  assign v_timeout_err = use_big ? b_timeout_err : s_timeout_err;
  assign v_mul_a       = use_big ? b_mul_a       : s_mul_a;
  assign v_mul_b       = use_big ? b_mul_b       : s_mul_b;
  assign v_res_z       = use_big ? b_res_z       : s_res_z;
  assign v_res_tag     = use_big ? b_res_tag     : s_res_tag;
  assign v_res_cycles  = use_big ? b_res_cycles  : s_res_cycles;

  always #5 clk = ~clk;

  fpu_mult_initiator #(.TAG_W(TAG_W), .TIMEOUT(16)) u_small (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(s_op_ready),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_a_stb(s_mul_a_stb), .mul_b_stb(s_mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(s_mul_z_ack),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_z(s_res_z), .res_tag(s_res_tag),
    .res_cycles(s_res_cycles), .busy(s_busy), .timeout_err(s_timeout_err)
  );

  fpu_mult_initiator #(.TAG_W(TAG_W), .TIMEOUT(100000)) u_big (
    .clk(clk), .rst(rst_big), .op_valid(op_valid), .op_ready(b_op_ready),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_a_stb(b_mul_a_stb), .mul_b_stb(b_mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(b_mul_z_ack),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_z(b_res_z), .res_tag(b_res_tag),
    .res_cycles(b_res_cycles), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  // Full transaction: issue, slave with given ack/product delays, then
  // downstream accepting after rr_dly cycles. z_dly >= 1 is the number of
  // edges from the B transfer to the product transfer.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                        input logic [TAG_W-1:0] tag,
                        input int a_dly, input int b_dly, input int z_dly, input int rr_dly);
    exp_t e, g;
    int   tot;
    tot   = a_dly + b_dly + z_dly + 2;
    e.z   = z;
    e.tag = tag;
    e.cyc = (tot > 65535) ? 16'hFFFF : 16'(tot);
    sb.push_back(e);

    checks++; if (v_op_ready !== 1'b1) begin errors++; $display("FAIL op_ready_idle got %b want 1", v_op_ready); end
    op_valid = 1'b1; op_a = a; op_b = b; op_tag = tag;
    @(negedge clk);
    op_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_tag = TAG_W'($urandom);
    checks++;
    if ({v_mul_a_stb, v_mul_b_stb, v_busy, v_op_ready, v_mul_a} !== {4'b1010, a}) begin
      errors++; $display("FAIL issue got stb_a/stb_b/busy/rdy=%b%b%b%b a=%h want 1010 a=%h",
                         v_mul_a_stb, v_mul_b_stb, v_busy, v_op_ready, v_mul_a, a);
    end

    // A phase; a stray mul_b_ack here must not advance anything
    mul_b_ack = 1'b1;
    repeat (a_dly) begin
      @(negedge clk);
      checks++;
      if ({v_mul_a_stb, v_mul_b_stb, v_mul_a} !== {2'b10, a}) begin
        errors++; $display("FAIL a_hold got stb_a/stb_b=%b%b a=%h want 10 a=%h",
                           v_mul_a_stb, v_mul_b_stb, v_mul_a, a);
      end
    end
    mul_b_ack = 1'b0;
    mul_a_ack = 1'b1;
    @(negedge clk);
    mul_a_ack = 1'b0;
    checks++;
    if ({v_mul_a_stb, v_mul_b_stb, v_mul_b} !== {2'b01, b}) begin
      errors++; $display("FAIL a_xfer got stb_a/stb_b=%b%b b=%h want 01 b=%h",
                         v_mul_a_stb, v_mul_b_stb, v_mul_b, b);
    end

    // B phase
    repeat (b_dly) begin
      @(negedge clk);
      checks++;
      if ({v_mul_b_stb, v_mul_z_ack} !== 2'b10) begin
        errors++; $display("FAIL b_hold got stb_b/zack=%b%b want 10", v_mul_b_stb, v_mul_z_ack);
      end
    end
    mul_b_ack = 1'b1;
    @(negedge clk);
    mul_b_ack = 1'b0;
    checks++;
    if ({v_mul_b_stb, v_mul_z_ack} !== 2'b01) begin
      errors++; $display("FAIL b_xfer got stb_b/zack=%b%b want 01", v_mul_b_stb, v_mul_z_ack);
    end

    // Product phase
    repeat (z_dly - 1) @(negedge clk);
    checks++;
    if ({v_res_valid, v_mul_z_ack} !== 2'b01) begin
      errors++; $display("FAIL z_wait got rv/zack=%b%b want 01", v_res_valid, v_mul_z_ack);
    end
    mul_z = z; mul_z_stb = 1'b1;
    @(negedge clk);
    mul_z_stb = 1'b0; mul_z = $urandom;
    checks++;
    if ({v_res_valid, v_mul_z_ack} !== 2'b10) begin
      errors++; $display("FAIL z_xfer got rv/zack=%b%b want 10", v_res_valid, v_mul_z_ack);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL sb_empty got result want none pending");
    end else begin
      g = sb.pop_front();
      checks++; if (v_res_z !== g.z) begin errors++; $display("FAIL res_z got %h want %h", v_res_z, g.z); end
      checks++; if (v_res_tag !== g.tag) begin errors++; $display("FAIL res_tag got %h want %h", v_res_tag, g.tag); end
      checks++; if (v_res_cycles !== g.cyc) begin errors++; $display("FAIL res_cycles got %0d want %0d", v_res_cycles, g.cyc); end
    end

    // Result backpressure: outputs held, new ops ignored
    repeat (rr_dly) begin
      op_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({v_res_valid, v_op_ready, v_mul_a_stb, v_res_z, v_res_tag} !== {3'b100, z, tag}) begin
        errors++; $display("FAIL res_hold got rv/rdy/stb_a=%b%b%b z=%h tag=%h want 100 z=%h tag=%h",
                           v_res_valid, v_op_ready, v_mul_a_stb, v_res_z, v_res_tag, z, tag);
      end
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({v_res_valid, v_op_ready, v_busy} !== 3'b010) begin
      errors++; $display("FAIL res_done got rv/rdy/busy=%b%b%b want 010", v_res_valid, v_op_ready, v_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_big = 1'b1; use_big = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; op_tag = '0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({v_op_ready, v_mul_a_stb, v_mul_b_stb, v_mul_z_ack, v_res_valid, v_busy, v_timeout_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b%b%b%b%b%b%b want 0000000", v_op_ready, v_mul_a_stb,
                         v_mul_b_stb, v_mul_z_ack, v_res_valid, v_busy, v_timeout_err);
    end
    checks++;
    if ({v_mul_a, v_mul_b, v_res_z, v_res_tag, v_res_cycles} !== '0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h z=%h tag=%h cyc=%h want 0",
                         v_mul_a, v_mul_b, v_res_z, v_res_tag, v_res_cycles);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (v_op_ready !== 1'b1) begin errors++; $display("FAIL reset_release got rdy=%b want 1", v_op_ready); end
  endtask

  task automatic test_ideal();
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 4'd3, 0, 0, 5, 0);
  endtask

  task automatic test_a_delay();
    run_op(32'h3F800000, 32'h41200000, 32'h41200000, 4'd5, 7, 0, 1, 0);
  endtask

  task automatic test_watchdog_rearm();
    // Each wait is under TIMEOUT but their sum is well over it
    run_op(32'h40A00000, 32'h40A00000, 32'h41C80000, 4'd6, 12, 12, 12, 0);
  endtask

  task automatic test_res_backpressure();
    run_op(32'hC0000000, 32'h40800000, 32'hC1000000, 4'd9, 0, 1, 2, 18);
  endtask

  task automatic test_back_to_back();
    run_op(32'h7F800000, 32'h00000000, FLOAT32_QNAN, 4'hA, 0, 0, 1, 0);
    run_op(32'h3F000000, 32'h3F000000, 32'h3E800000, 4'hB, 1, 2, 3, 0);
  endtask

  task automatic test_timeout();
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_tag = 4'h7; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    mul_a_ack = 1'b1; @(negedge clk); mul_a_ack = 1'b0;
    mul_b_ack = 1'b1; @(negedge clk); mul_b_ack = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({v_busy, v_mul_z_ack, v_timeout_err} !== 3'b110) begin
        errors++; $display("FAIL wait_z_%0d got busy/zack/terr=%b%b%b want 110", k, v_busy, v_mul_z_ack, v_timeout_err);
      end
    end
    @(negedge clk);
    checks++;
    if ({v_busy, v_mul_z_ack, v_timeout_err, v_res_valid, v_op_ready} !== 5'b00101) begin
      errors++; $display("FAIL timeout got busy/zack/terr/rv/rdy=%b%b%b%b%b want 00101",
                         v_busy, v_mul_z_ack, v_timeout_err, v_res_valid, v_op_ready);
    end
    run_op(32'h40400000, 32'h40400000, 32'h41100000, 4'h1, 0, 0, 2, 0);
    checks++; if (v_timeout_err !== 1'b1) begin errors++; $display("FAIL terr_sticky got %b want 1", v_timeout_err); end
  endtask

  task automatic test_reset_mid();
    op_a = 32'h40000000; op_b = 32'h40000000; op_tag = 4'h2; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    mul_a_ack = 1'b1; @(negedge clk); mul_a_ack = 1'b0;
    checks++; if (v_mul_b_stb !== 1'b1) begin errors++; $display("FAIL in_send_b got stb_b=%b want 1", v_mul_b_stb); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({v_mul_a_stb, v_mul_b_stb, v_mul_z_ack, v_busy, v_op_ready, v_timeout_err} !== 6'b0) begin
      errors++; $display("FAIL rst_mid got stb_a/stb_b/zack/busy/rdy/terr=%b%b%b%b%b%b want 000000",
                         v_mul_a_stb, v_mul_b_stb, v_mul_z_ack, v_busy, v_op_ready, v_timeout_err);
    end
    checks++; if ({v_mul_a, v_mul_b} !== 64'h0) begin errors++; $display("FAIL rst_mid_data got a=%h b=%h want 0", v_mul_a, v_mul_b); end
    rst = 1'b0;
    mul_b_ack = 1'b1; mul_z_stb = 1'b1; mul_z = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({v_mul_b_stb, v_mul_z_ack, v_res_valid, v_busy, v_op_ready} !== 5'b00001) begin
        errors++; $display("FAIL stray_ack got stb_b/zack/rv/busy/rdy=%b%b%b%b%b want 00001",
                           v_mul_b_stb, v_mul_z_ack, v_res_valid, v_busy, v_op_ready);
      end
    end
    mul_b_ack = 1'b0; mul_z_stb = 1'b0;
    run_op(32'h40800000, 32'h40000000, 32'h41000000, 4'h4, 0, 0, 1, 1);
  endtask

  task automatic test_saturation();
    use_big = 1'b1;
    rst_big = 1'b0;
    @(negedge clk);
    run_op(32'h3F800000, 32'h40000000, 32'h40000000, 4'hC, 0, 0, 70000, 0);
  endtask

  initial begin
    rst = 1'b1; rst_big = 1'b1; use_big = 1'b0;
    test_reset();
    test_ideal();
    test_a_delay();
    test_watchdog_rearm();
    test_res_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
